// File: rtl/term_pkg.sv
// Shared types and constants for the terminate (branch/jump) issue controller.
package term_pkg;

    localparam logic [3:0] OP_TERM_ALWAYS = 4'b1111;
    localparam logic [3:0] OP_TERM_COND   = 4'b1110;

    // The op register carries tags up to this width; narrower TAG_W values are zero-extended.
    localparam int TERM_TAG_MAX_W = 8;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } op_state_e;

    typedef struct packed {
        logic [3:0]                opcode;
        logic [15:0]               reg_base_val;
        logic [3:0]                flag_index;
        logic [7:0]                flag_vals;
        logic [7:0]                offset;
        logic [3:0]                immediate;
        logic [TERM_TAG_MAX_W-1:0] tag;
    } term_op_t;

endpackage

// File: rtl/terminate_issue_ctrl_if.sv
// Request bus from the reservation-station slots and result handshake toward redirect/ROB.
interface terminate_issue_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [4*NUM_REQ-1:0]     req_opcode;
    logic [16*NUM_REQ-1:0]    req_reg_base_val;
    logic [4*NUM_REQ-1:0]     req_flag_index;
    logic [8*NUM_REQ-1:0]     req_flag_vals;
    logic [8*NUM_REQ-1:0]     req_offset;
    logic [4*NUM_REQ-1:0]     req_immediate;
    logic [TAG_W*NUM_REQ-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_grant;

    logic                     res_valid;
    logic                     res_ready;
    logic [TAG_W-1:0]         res_tag;
    logic                     res_taken;
    logic [15:0]              res_addr;

    // Handshakes: a slot transfers when req_valid[i] & req_grant[i] at a rising edge; a result
    // transfers when res_valid & res_ready at a rising edge. res_* are stable while res_valid & !res_ready.
    modport master (
        output req_valid, req_opcode, req_reg_base_val, req_flag_index, req_flag_vals,
               req_offset, req_immediate, req_tag, res_ready,
        input  req_grant, res_valid, res_tag, res_taken, res_addr
    );

    modport slave (
        input  req_valid, req_opcode, req_reg_base_val, req_flag_index, req_flag_vals,
               req_offset, req_immediate, req_tag, res_ready,
        output req_grant, res_valid, res_tag, res_taken, res_addr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i, wrapping, as one-hot plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end
endmodule

// File: rtl/terminate_issue_ctrl.sv
// Issues terminate ops from NUM_REQ slots onto the shared terminate_pipeline and buffers one result.
// Optional macro TERM_PERF_CNT_EN adds taken / not-taken event counters.
module terminate_issue_ctrl
    import term_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    terminate_issue_ctrl_if.slave        bus,
    output logic [3:0]                   tp_opcode,
    output logic [15:0]                  tp_reg_base_val,
    output logic [3:0]                   tp_flag_index,
    output logic [7:0]                   tp_flag_vals,
    output logic [7:0]                   tp_offset,
    output logic [3:0]                   tp_immediate,
    input  logic [15:0]                  tp_result_addr,
    input  logic                         tp_result_valid,
`ifdef TERM_PERF_CNT_EN
    output logic [15:0]                  perf_taken_cnt,
    output logic [15:0]                  perf_nottaken_cnt,
`endif
    output logic                         dbg_state_o,
    output logic [$clog2(NUM_REQ)-1:0]   dbg_rr_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    op_state_e        state_q;
    term_op_t         op_q, op_d;
    logic [IDX_W-1:0] rr_q, rr_d, arb_idx;
    logic [NUM_REQ-1:0] arb_req, arb_grant;
    logic             res_valid_q, res_taken_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [15:0]      res_addr_q;
    logic             adv, can_issue, any_grant;
    logic             tag_unused;

    assign adv       = (state_q == ST_LOADED) && (!res_valid_q || bus.res_ready);
    // Reset is folded in so the grant is silent while rst_n is held low.
    assign can_issue = rst_n && !flush && ((state_q == ST_EMPTY) || adv);
    assign arb_req   = bus.req_valid & {NUM_REQ{can_issue}};
    assign any_grant = |arb_grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (arb_req),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    always_comb begin
        op_d              = '0;
        op_d.opcode       = bus.req_opcode[4*int'(arb_idx) +: 4];
        op_d.reg_base_val = bus.req_reg_base_val[16*int'(arb_idx) +: 16];
        op_d.flag_index   = bus.req_flag_index[4*int'(arb_idx) +: 4];
        op_d.flag_vals    = bus.req_flag_vals[8*int'(arb_idx) +: 8];
        op_d.offset       = bus.req_offset[8*int'(arb_idx) +: 8];
        op_d.immediate    = bus.req_immediate[4*int'(arb_idx) +: 4];
        op_d.tag          = TERM_TAG_MAX_W'(bus.req_tag[TAG_W*int'(arb_idx) +: TAG_W]);
        rr_d              = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
    end

    // Flush drops both stages but leaves the round-robin pointer and op fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            op_q        <= '0;
            rr_q        <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_taken_q <= 1'b0;
            res_addr_q  <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            res_valid_q <= 1'b0;
        end else begin
            if (adv) begin
                res_valid_q <= 1'b1;
                res_tag_q   <= op_q.tag[TAG_W-1:0];
                res_taken_q <= tp_result_valid;
                res_addr_q  <= tp_result_valid ? tp_result_addr : 16'h0000;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (any_grant) begin
                op_q    <= op_d;
                state_q <= ST_LOADED;
                rr_q    <= rr_d;
            end else if (adv) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign bus.req_grant   = arb_grant;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_tag     = res_tag_q;
    assign bus.res_taken   = res_taken_q;
    assign bus.res_addr    = res_addr_q;

    assign tp_opcode       = op_q.opcode;
    assign tp_reg_base_val = op_q.reg_base_val;
    assign tp_flag_index   = op_q.flag_index;
    assign tp_flag_vals    = op_q.flag_vals;
    assign tp_offset       = op_q.offset;
    assign tp_immediate    = op_q.immediate;

    assign dbg_state_o     = (state_q == ST_LOADED);
    assign dbg_rr_o        = rr_q;
    assign tag_unused      = ^op_q.tag;

`ifdef TERM_PERF_CNT_EN
    logic [15:0] perf_taken_q, perf_nottaken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_taken_q    <= '0;
            perf_nottaken_q <= '0;
        end else if (adv && !flush) begin
            if (tp_result_valid) perf_taken_q    <= perf_taken_q + 16'd1;
            else                 perf_nottaken_q <= perf_nottaken_q + 16'd1;
        end
    end

    assign perf_taken_cnt    = perf_taken_q;
    assign perf_nottaken_cnt = perf_nottaken_q;
`endif
endmodule

// File: tb/tb_terminate_issue_ctrl.sv
// Bench for terminate_issue_ctrl: directed vector table, reset/flush sequences, random vs. queue model.
module tb_terminate_issue_ctrl;
    import term_pkg::*;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int EW = 1 + 16 + TW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    terminate_issue_ctrl_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

    logic [3:0]  tp_opcode, tp_flag_index, tp_immediate;
    logic [15:0] tp_reg_base_val, tp_result_addr;
    logic [7:0]  tp_flag_vals, tp_offset;
    logic        tp_result_valid;
    logic        dbg_state;
    logic [1:0]  dbg_rr;
`ifdef TERM_PERF_CNT_EN
    logic [15:0] perf_taken_cnt, perf_nottaken_cnt;
`endif

    // Stub terminate_pipeline
    assign tp_result_addr  = tp_reg_base_val + {8'h00, tp_offset};
    assign tp_result_valid = (tp_opcode == OP_TERM_ALWAYS);

    terminate_issue_ctrl #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .bus               (bus),
        .tp_opcode         (tp_opcode),
        .tp_reg_base_val   (tp_reg_base_val),
        .tp_flag_index     (tp_flag_index),
        .tp_flag_vals      (tp_flag_vals),
        .tp_offset         (tp_offset),
        .tp_immediate      (tp_immediate),
        .tp_result_addr    (tp_result_addr),
        .tp_result_valid   (tp_result_valid),
`ifdef TERM_PERF_CNT_EN
        .perf_taken_cnt    (perf_taken_cnt),
        .perf_nottaken_cnt (perf_nottaken_cnt),
`endif
        .dbg_state_o       (dbg_state),
        .dbg_rr_o          (dbg_rr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive_all(input logic [3:0] rv, input logic [3:0] op, input logic [15:0] base,
                             input logic [7:0] off, input logic [TW-1:0] tag,
                             input logic ready, input logic fl);
        bus.req_valid = rv;
        for (int i = 0; i < N; i++) begin
            bus.req_opcode[4*i +: 4]        = op;
            bus.req_reg_base_val[16*i +: 16] = base;
            bus.req_flag_index[4*i +: 4]    = 4'(i);
            bus.req_flag_vals[8*i +: 8]     = 8'hA5;
            bus.req_offset[8*i +: 8]        = off;
            bus.req_immediate[4*i +: 4]     = 4'h3;
            bus.req_tag[TW*i +: TW]         = tag;
        end
        bus.res_ready = ready;
        flush         = fl;
    endtask

    // Directed vector table
    typedef struct {
        logic [3:0]    rv;
        logic [3:0]    op;
        logic [15:0]   base;
        logic [7:0]    off;
        logic [TW-1:0] tag;
        logic          ready;
        logic          fl;
        logic [3:0]    e_grant;
        logic          e_rv;
        logic          e_taken;
        logic [15:0]   e_addr;
        logic [TW-1:0] e_tag;
        logic          e_st;
        logic [1:0]    e_rr;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic [3:0] rv, logic [3:0] op, logic [15:0] base, logic [7:0] off,
                                logic [TW-1:0] tag, logic ready, logic fl, logic [3:0] eg,
                                logic erv, logic etk, logic [15:0] ea, logic [TW-1:0] et,
                                logic est, logic [1:0] err);
        vec_t v;
        v.rv = rv; v.op = op; v.base = base; v.off = off; v.tag = tag; v.ready = ready; v.fl = fl;
        v.e_grant = eg; v.e_rv = erv; v.e_taken = etk; v.e_addr = ea; v.e_tag = et;
        v.e_st = est; v.e_rr = err;
        return v;
    endfunction

    // Reference model: in-order queue of expected results {taken, addr, tag}
    logic [EW-1:0] exp_q[$];
    bit            m_shown;
    int            m_rr;
    int            m_taken, m_nottaken;
    logic [3:0]    r_op[N];
    logic [15:0]   r_base[N];
    logic [7:0]    r_off[N];
    logic [TW-1:0] r_tag[N];

    function automatic int pick(logic [3:0] rv, int rr);
        for (int k = 0; k < N; k++) begin
            if (rv[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(4'b0100, 4'hF, 16'h1000, 8'h20, 5'd5, 1, 0, 4'b0100, 0, 0, 16'h0000, 5'd0, 0, 2'd0);
        vecs[1]  = mk(4'b0000, 4'hF, 16'h1000, 8'h20, 5'd5, 1, 0, 4'b0000, 0, 0, 16'h0000, 5'd0, 1, 2'd3);
        vecs[2]  = mk(4'b0000, 4'hE, 16'h2000, 8'h10, 5'd7, 1, 0, 4'b0000, 1, 1, 16'h1020, 5'd5, 0, 2'd3);
        vecs[3]  = mk(4'b0001, 4'hE, 16'h2000, 8'h10, 5'd7, 1, 0, 4'b0001, 0, 0, 16'h0000, 5'd0, 0, 2'd3);
        vecs[4]  = mk(4'b0000, 4'hE, 16'h2000, 8'h10, 5'd7, 1, 0, 4'b0000, 0, 0, 16'h0000, 5'd0, 1, 2'd1);
        vecs[5]  = mk(4'b1111, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0010, 1, 0, 16'h0000, 5'd7, 0, 2'd1);
        vecs[6]  = mk(4'b1111, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0100, 0, 0, 16'h0000, 5'd0, 1, 2'd2);
        vecs[7]  = mk(4'b1111, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b1000, 1, 1, 16'h3004, 5'd9, 1, 2'd3);
        vecs[8]  = mk(4'b1111, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0001, 1, 1, 16'h3004, 5'd9, 1, 2'd0);
        vecs[9]  = mk(4'b1111, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0010, 1, 1, 16'h3004, 5'd9, 1, 2'd1);
        vecs[10] = mk(4'b0000, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0000, 1, 1, 16'h3004, 5'd9, 1, 2'd2);
        vecs[11] = mk(4'b0000, 4'hF, 16'h3000, 8'h04, 5'd9, 1, 0, 4'b0000, 1, 1, 16'h3004, 5'd9, 0, 2'd2);
        vecs[12] = mk(4'b0011, 4'hF, 16'h4000, 8'h01, 5'd3, 0, 0, 4'b0001, 0, 0, 16'h0000, 5'd0, 0, 2'd2);
        vecs[13] = mk(4'b0011, 4'hF, 16'h4000, 8'h01, 5'd4, 0, 0, 4'b0010, 0, 0, 16'h0000, 5'd0, 1, 2'd1);
        vecs[14] = mk(4'b0011, 4'hF, 16'h4000, 8'h01, 5'd6, 0, 0, 4'b0000, 1, 1, 16'h4001, 5'd3, 1, 2'd2);
        vecs[15] = mk(4'b0011, 4'hF, 16'h4000, 8'h01, 5'd6, 0, 0, 4'b0000, 1, 1, 16'h4001, 5'd3, 1, 2'd2);
        vecs[16] = mk(4'b0011, 4'hF, 16'h4000, 8'h01, 5'd6, 1, 0, 4'b0001, 1, 1, 16'h4001, 5'd3, 1, 2'd2);
        vecs[17] = mk(4'b0000, 4'hF, 16'h4000, 8'h01, 5'd6, 1, 0, 4'b0000, 1, 1, 16'h4001, 5'd4, 1, 2'd1);
        vecs[18] = mk(4'b0000, 4'hF, 16'h4000, 8'h01, 5'd6, 1, 0, 4'b0000, 1, 1, 16'h4001, 5'd6, 0, 2'd1);
        vecs[19] = mk(4'b0000, 4'hF, 16'h4000, 8'h01, 5'd6, 1, 0, 4'b0000, 0, 0, 16'h0000, 5'd0, 0, 2'd1);
        vecs[20] = mk(4'b0001, 4'hF, 16'h5000, 8'h02, 5'd1, 0, 0, 4'b0001, 0, 0, 16'h0000, 5'd0, 0, 2'd1);
        vecs[21] = mk(4'b0010, 4'hF, 16'h5000, 8'h02, 5'd2, 0, 0, 4'b0010, 0, 0, 16'h0000, 5'd0, 1, 2'd1);
        vecs[22] = mk(4'b0000, 4'hF, 16'h5000, 8'h02, 5'd2, 0, 0, 4'b0000, 1, 1, 16'h5002, 5'd1, 1, 2'd2);
        vecs[23] = mk(4'b1111, 4'hF, 16'h5000, 8'h02, 5'd2, 1, 1, 4'b0000, 1, 1, 16'h5002, 5'd1, 1, 2'd2);
        vecs[24] = mk(4'b0100, 4'hF, 16'h5000, 8'h02, 5'd8, 1, 0, 4'b0100, 0, 0, 16'h0000, 5'd0, 0, 2'd2);
        vecs[25] = mk(4'b0000, 4'hF, 16'h5000, 8'h02, 5'd8, 1, 0, 4'b0000, 0, 0, 16'h0000, 5'd0, 1, 2'd3);
        vecs[26] = mk(4'b0000, 4'hF, 16'h5000, 8'h02, 5'd8, 1, 0, 4'b0000, 1, 1, 16'h5002, 5'd8, 0, 2'd3);
        vecs[27] = mk(4'b0000, 4'hF, 16'h5000, 8'h02, 5'd8, 1, 0, 4'b0000, 0, 0, 16'h0000, 5'd0, 0, 2'd3);

        // Reset state
        drive_all(4'b1111, 4'hF, 16'h1234, 8'h11, 5'd3, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset res_tag", 32'(bus.res_tag), 32'd0);
        check("reset res_taken", 32'(bus.res_taken), 32'd0);
        check("reset res_addr", 32'(bus.res_addr), 32'd0);
        check("reset req_grant", 32'(bus.req_grant), 32'd0);
        check("reset tp_fields", {tp_opcode, tp_reg_base_val, tp_flag_index, tp_immediate},
              32'd0);
        check("reset tp_bytes", {16'h0, tp_flag_vals, tp_offset}, 32'd0);
        check("reset rr", 32'(dbg_rr), 32'd0);
`ifdef TERM_PERF_CNT_EN
        check("reset perf", {perf_taken_cnt, perf_nottaken_cnt}, 32'd0);
`endif
        drive_all(4'b0000, 4'hF, 16'h0000, 8'h00, 5'd0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Directed table: single issue, not taken, fairness, backpressure, flush
        for (int r = 0; r < 28; r++) begin
            @(posedge clk);
            #1;
            drive_all(vecs[r].rv, vecs[r].op, vecs[r].base, vecs[r].off, vecs[r].tag,
                      vecs[r].ready, vecs[r].fl);
            @(negedge clk);
            check($sformatf("vec%0d grant", r), 32'(bus.req_grant), 32'(vecs[r].e_grant));
            check($sformatf("vec%0d res_valid", r), 32'(bus.res_valid), 32'(vecs[r].e_rv));
            check($sformatf("vec%0d state", r), 32'(dbg_state), 32'(vecs[r].e_st));
            check($sformatf("vec%0d rr", r), 32'(dbg_rr), 32'(vecs[r].e_rr));
            if (vecs[r].e_rv) begin
                check($sformatf("vec%0d result", r), {bus.res_taken, bus.res_tag, bus.res_addr},
                      {vecs[r].e_taken, vecs[r].e_tag, vecs[r].e_addr});
            end
        end

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        drive_all(4'b0100, 4'hF, 16'h6000, 8'h10, 5'd11, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_all(4'b0010, 4'hF, 16'h6000, 8'h10, 5'd12, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_all(4'b1111, 4'hF, 16'h6000, 8'h10, 5'd13, 1'b0, 1'b0);
        check("pre_rst res_valid", 32'(bus.res_valid), 32'd1);
        check("pre_rst state", 32'(dbg_state), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst res_valid", 32'(bus.res_valid), 32'd0);
        check("async_rst grant", 32'(bus.req_grant), 32'd0);
        check("async_rst state", 32'(dbg_state), 32'd0);
        check("async_rst rr", 32'(dbg_rr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_all(4'b1111, 4'hF, 16'h6000, 8'h10, 5'd14, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst first grant", 32'(bus.req_grant), 32'b0001);
`ifdef TERM_PERF_CNT_EN
        check("post_rst perf", {perf_taken_cnt, perf_nottaken_cnt}, 32'd0);
`endif

        // Randomized run against the queue model
        @(posedge clk); #1;
        drive_all(4'b0000, 4'hF, 16'h0000, 8'h00, 5'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_shown    = 0;
        m_rr       = 0;
        m_taken    = 0;
        m_nottaken = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int            op_occ, g;
            bit            moving, can;
            logic [3:0]    rv, exp_grant;
            logic          ready, fl, tk;
            logic [EW-1:0] item;
            @(posedge clk);
            #1;
            rv    = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 2))
                    0:       r_op[i] = OP_TERM_ALWAYS;
                    1:       r_op[i] = OP_TERM_COND;
                    default: r_op[i] = 4'($urandom_range(0, 15));
                endcase
                r_base[i] = 16'($urandom);
                r_off[i]  = 8'($urandom);
                r_tag[i]  = TW'($urandom);
                bus.req_opcode[4*i +: 4]         = r_op[i];
                bus.req_reg_base_val[16*i +: 16] = r_base[i];
                bus.req_flag_index[4*i +: 4]     = 4'($urandom);
                bus.req_flag_vals[8*i +: 8]      = 8'($urandom);
                bus.req_offset[8*i +: 8]         = r_off[i];
                bus.req_immediate[4*i +: 4]      = 4'($urandom);
                bus.req_tag[TW*i +: TW]          = r_tag[i];
            end
            bus.req_valid = rv;
            bus.res_ready = ready;
            flush         = fl;

            @(negedge clk);
            op_occ    = exp_q.size() - int'(m_shown);
            moving    = (op_occ > 0) && (!m_shown || ready);
            can       = !fl && ((op_occ == 0) || moving);
            g         = can ? pick(rv, m_rr) : -1;
            exp_grant = (g >= 0) ? 4'(1 << g) : 4'b0000;
            check($sformatf("rand%0d grant", cyc), 32'(bus.req_grant), 32'(exp_grant));
            check($sformatf("rand%0d res_valid", cyc), 32'(bus.res_valid), 32'(m_shown));
            check($sformatf("rand%0d state", cyc), 32'(dbg_state), 32'(op_occ > 0));
            check($sformatf("rand%0d rr", cyc), 32'(dbg_rr), 32'(m_rr));
            if (m_shown) begin
                check($sformatf("rand%0d result", cyc),
                      32'({bus.res_taken, bus.res_addr, bus.res_tag}), 32'(exp_q[0]));
            end

            if (fl) begin
                exp_q.delete();
                m_shown = 0;
            end else begin
                if (m_shown && ready) begin
                    void'(exp_q.pop_front());
                    m_shown = 0;
                end
                if (!m_shown && exp_q.size() > 0) begin
                    m_shown = 1;
                    if (exp_q[0][EW-1]) m_taken++;
                    else                m_nottaken++;
                end
                if (g >= 0) begin
                    tk   = (r_op[g] == OP_TERM_ALWAYS);
                    item = {tk, tk ? 16'(r_base[g] + {8'h00, r_off[g]}) : 16'h0000, r_tag[g]};
                    exp_q.push_back(item);
                    m_rr = (g + 1) % N;
                end
            end
        end
`ifdef TERM_PERF_CNT_EN
        check("perf taken total", 32'(perf_taken_cnt), 32'(m_taken));
        check("perf nottaken total", 32'(perf_nottaken_cnt), 32'(m_nottaken));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/terminate_issue_ctrl.md
Name: terminate_issue_ctrl

Overview:
- Schedules terminate (branch/jump) micro-ops from NUM_REQ reservation-station slots onto the single shared, combinational terminate_pipeline datapath.
- Round-robin arbitrates requesters and registers the chosen operands, which drive the datapath.
- Captures the datapath's address/valid into a one-deep result register with a valid/ready handshake toward the redirect/ROB logic.
- Supports a flush that kills in-flight work.

Parameters:
- NUM_REQ, 4, number of requesting slots (2..8).
- TAG_W, 5, ROB tag width carried with each op.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of op and result stages
- req_valid  in  NUM_REQ  per-slot request
- req_opcode  in  4*NUM_REQ  slot i at [4i+3:4i]
- req_reg_base_val  in  16*NUM_REQ  base address
- req_flag_index  in  4*NUM_REQ  flag bit selector
- req_flag_vals  in  8*NUM_REQ  flag snapshot
- req_offset  in  8*NUM_REQ  address offset
- req_immediate  in  4*NUM_REQ  condition immediate
- req_tag  in  TAG_W*NUM_REQ  ROB tag
- req_grant  out  NUM_REQ  one-hot; slot accepted when req_valid[i] & req_grant[i]
- tp_opcode  out  4  to terminate_pipeline
- tp_reg_base_val  out  16  to terminate_pipeline
- tp_flag_index  out  4  to terminate_pipeline
- tp_flag_vals  out  8  to terminate_pipeline
- tp_offset  out  8  to terminate_pipeline
- tp_immediate  out  4  to terminate_pipeline
- tp_result_addr  in  16  from terminate_pipeline
- tp_result_valid  in  1  from terminate_pipeline; 1 = terminate taken
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_tag  out  TAG_W  tag of result
- res_taken  out  1  captured tp_result_valid
- res_addr  out  16  tp_result_addr if taken, else 16'h0000

Behaviour:
- Reset (async, rst_n low):
  - op_valid=0, res_valid=0, res_tag=0, res_taken=0, res_addr=0.
  - All tp_* outputs 0; round-robin pointer rr=0; req_grant=0.
- Op-stage FSM, two states:
  - EMPTY: no op registered.
  - LOADED: op register valid; its fields drive tp_* directly (no combinational path from req_* to tp_*).
- Advance: adv = LOADED & (!res_valid | res_ready).
- On adv, the edge loads res_* from tp_result_addr/tp_result_valid and op_tag, and sets res_valid=1.
- Grant condition: can_issue = !flush & (EMPTY | adv).
- Grant: if can_issue, req_grant = one-hot of first i with req_valid[i], searching from rr upward with wrap; otherwise 0. req_grant is combinational and depends on req_valid.
- On grant:
  - Capture slot fields into the op register → LOADED.
  - rr = (granted index + 1) mod NUM_REQ.
- adv with no grant → EMPTY.
- LOADED & !adv → hold; tp_* stable.
- Result handshake: res_valid & res_ready with no adv clears res_valid. res_* hold while res_valid & !res_ready.
- Throughput and latency:
  - One op per cycle when the consumer is always ready.
  - Accept at edge k → res_valid at edge k+1.
  - Accept and drain in the same cycle is allowed.
- tp_* hold their last value in EMPTY; their content is don't-care.
- flush:
  - Next edge: op_valid=0, res_valid=0, no grant that cycle, rr unchanged.
  - flush overrides res_ready and adv.
- Simultaneous accept and flush cannot occur, because grant is suppressed during flush.
- res_addr is zeroed when not taken; no address arithmetic is done here.

Optional Feature:
- Macro TERM_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_taken_cnt [15:0] and perf_nottaken_cnt [15:0].
  - Each increments on every adv, per the captured taken value.
  - Wrap at 16'hFFFF→0; reset to 0; not cleared by flush.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package term_pkg: opcode constants OP_TERM_ALWAYS=4'b1111, OP_TERM_COND=4'b1110, and packed struct term_op_t {opcode, reg_base_val, flag_index, flag_vals, offset, immediate, tag}.
- One sub-module: rr_arbiter, parameterized on NUM_REQ; inputs req and ptr; output one-hot grant and encoded index.

Test Plan:
- The bench drives a stub terminate_pipeline: addr = base + offset, valid = (opcode==4'hF).
- Single issue:
  - Stimulus: slot 2 valid, opcode F, base 16'h1000, offset 8'h20, tag 5, res_ready=1.
  - Response: req_grant=4'b0100 that cycle; next edge res_valid=1, res_addr=16'h1020, res_taken=1, res_tag=5; rr=3.
- Round-robin fairness:
  - Stimulus: all four slots valid continuously.
  - Response: grants 0,1,2,3,0 on consecutive cycles; one result per cycle.
- Backpressure:
  - Stimulus: res_ready=0 with two slots valid.
  - Response: first result held stable; second op LOADED; no third grant.
  - Then raise res_ready: results drain in order, with a new grant in the same cycle.
- Not taken:
  - Stimulus: opcode E, base 16'h2000.
  - Response: res_taken=0, res_addr=16'h0000.
- Flush mid-operation:
  - Stimulus: LOADED and res_valid=1, assert flush for one cycle.
  - Response: req_grant=0 that cycle; next edge res_valid=0, op stage EMPTY; rr unchanged.
- Reset mid-operation:
  - Stimulus: drop rst_n asynchronously between edges while LOADED.
  - Response: res_valid and req_grant go 0 immediately; after release, first grant goes to slot 0.
  - With TERM_PERF_CNT_EN: counters read 0 after reset and match taken/not-taken totals after the round-robin test.
